// File: rtl/polybius_digit_serializer.sv
// Captures one Polybius-encrypted message and streams it out as ASCII digit pairs
// separated by SEP_CHAR, one character per valid/ready transfer.
module polybius_digit_serializer #(
    parameter int          MSG_LEN  = 6,
    parameter logic [7:0]  SEP_CHAR = 8'h20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*MSG_LEN-1:0]   in_text,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic                   out_last,
    output logic                   err
);

    localparam int              IW       = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [IW-1:0]   LAST_IDX = IW'(MSG_LEN - 1);

    typedef enum logic [1:0] {IDLE, TENS, UNITS, SEP} state_t;

    state_t                    state, state_nxt;
    logic [MSG_LEN-1:0][7:0]   msg;
    logic [IW-1:0]             idx;
    logic                      err_q;
    logic [7:0]                code, tens, units;
    logic                      code_ok;
    logic                      accept, xfer;

    assign code    = msg[idx];
    assign tens    = code / 8'd10;
    assign units   = code % 8'd10;
    assign code_ok = (code <= 8'd99) && (tens >= 8'd1) && (tens <= 8'd5)
                     && (units >= 8'd1) && (units <= 8'd5);

    assign accept = in_valid && in_ready;
    assign xfer   = out_valid && out_ready;

    // err_q latches the bad code one edge late; OR-ing in the TENS decode makes
    // err visible in the same cycle the '?' is first presented.
    assign err = err_q || ((state == TENS) && !code_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            msg   <= '0;
            idx   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                msg   <= in_text;
                idx   <= '0;
                err_q <= 1'b0;
            end else begin
                if ((state == TENS) && !code_ok)
                    err_q <= 1'b1;
                if ((state == SEP) && xfer)
                    idx <= idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b1;
        out_data  = 8'h00;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                if (in_valid)
                    state_nxt = TENS;
            end
            TENS: begin
                out_data = code_ok ? (8'h30 + tens) : 8'h3F;
                if (out_ready)
                    state_nxt = UNITS;
            end
            UNITS: begin
                out_data = code_ok ? (8'h30 + units) : 8'h3F;
                out_last = (idx == LAST_IDX);
                if (out_ready)
                    state_nxt = (idx == LAST_IDX) ? IDLE : SEP;
            end
            SEP: begin
                out_data = SEP_CHAR;
                if (out_ready)
                    state_nxt = TENS;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_polybius_digit_serializer.sv
// Directed bench for polybius_digit_serializer: a MSG_LEN=6 instance for the
// main scenarios and a MSG_LEN=1 instance for the single-code corner case.
module tb_polybius_digit_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [47:0] in_text = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;
    logic        err;

    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic [7:0]  in_text1 = '0;
    logic        out_valid1;
    logic        out_ready1 = 1'b1;
    logic [7:0]  out_data1;
    logic        out_last1;
    logic        err1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] rx_data [0:31];
    logic       rx_last [0:31];
    logic       rx_err  [0:31];
    int         rx_n, rx_cycles, rx_stall_bad, rx_rdy_bad;

    always #5 clk = ~clk;

    polybius_digit_serializer #(.MSG_LEN(6), .SEP_CHAR(8'h20)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_text(in_text), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .err(err));

    polybius_digit_serializer #(.MSG_LEN(1), .SEP_CHAR(8'h20)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_text(in_text1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1), .out_last(out_last1), .err(err1));

    function automatic logic [47:0] pack6(input int b0, b1, b2, b3, b4, b5);
        return {8'(b5), 8'(b4), 8'(b3), 8'(b2), 8'(b1), 8'(b0)};
    endfunction

    // Present a message at a negedge; it is accepted on the following posedge.
    task automatic send(input logic [47:0] text);
        in_text  = text;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Collect n characters, sampling at negedges; with bp, out_ready is random.
    task automatic recv(input int n, input bit bp);
        logic       held;
        logic [7:0] hold_d;
        logic       hold_l;
        held = 1'b0; hold_d = '0; hold_l = 1'b0;
        rx_n = 0; rx_cycles = 0; rx_stall_bad = 0; rx_rdy_bad = 0;
        while (rx_n < n && rx_cycles < 300) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (held && (!out_valid || out_data !== hold_d || out_last !== hold_l))
                rx_stall_bad++;
            if (in_ready)
                rx_rdy_bad++;
            if (out_valid && out_ready) begin
                rx_data[rx_n] = out_data;
                rx_last[rx_n] = out_last;
                rx_err[rx_n]  = err;
                rx_n++;
                held = 1'b0;
            end else if (out_valid) begin
                held = 1'b1; hold_d = out_data; hold_l = out_last;
            end
            @(negedge clk);
            rx_cycles++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        n_chk++;
        if ({in_ready, out_valid, out_last, out_data, err} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            $display("FAIL reset6: got rdy=%b vld=%b last=%b data=%h err=%b, want 1 0 0 00 0",
                     in_ready, out_valid, out_last, out_data, err);
        end else n_pass++;
        n_chk++;
        if ({in_ready1, out_valid1, out_last1, out_data1, err1} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            $display("FAIL reset1: got rdy=%b vld=%b last=%b data=%h err=%b, want 1 0 0 00 0",
                     in_ready1, out_valid1, out_last1, out_data1, err1);
        end else n_pass++;
    endtask

    task automatic test_basic;
        string exp;
        int bad, nl, nerr;
        exp = "23 15 31 31 34 52";
        send(pack6(23, 15, 31, 31, 34, 52));
        n_chk++;
        if (out_valid !== 1'b1) $display("FAIL basic_latency: out_valid=%b want 1", out_valid);
        else n_pass++;
        recv(17, 1'b0);
        bad = 0; nl = 0; nerr = 0;
        for (int i = 0; i < 17; i++) begin
            if (rx_data[i] !== exp[i]) bad++;
            if (rx_last[i]) nl++;
            if (rx_err[i] !== 1'b0) nerr++;
        end
        n_chk++;
        if (rx_n != 17 || bad != 0) $display("FAIL basic_seq: got %0d chars with %0d wrong, want 17 with 0", rx_n, bad);
        else n_pass++;
        n_chk++;
        if (rx_cycles != 17) $display("FAIL basic_rate: took %0d cycles, want 17", rx_cycles);
        else n_pass++;
        n_chk++;
        if (nl != 1 || rx_last[16] !== 1'b1) $display("FAIL basic_last: lasts=%0d final=%b, want 1 1", nl, rx_last[16]);
        else n_pass++;
        n_chk++;
        if (nerr != 0) $display("FAIL basic_err: err high on %0d chars, want 0", nerr);
        else n_pass++;
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL basic_idle: rdy=%b vld=%b want 1 0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        string exp;
        int bad;
        exp = "23 15 31 31 34 52";
        send(pack6(23, 15, 31, 31, 34, 52));
        recv(17, 1'b1);
        bad = 0;
        for (int i = 0; i < 17; i++) if (rx_data[i] !== exp[i]) bad++;
        n_chk++;
        if (rx_n != 17 || bad != 0) $display("FAIL bp_seq: got %0d chars with %0d wrong, want 17 with 0", rx_n, bad);
        else n_pass++;
        n_chk++;
        if (rx_stall_bad != 0) $display("FAIL bp_stable: %0d unstable stall cycles, want 0", rx_stall_bad);
        else n_pass++;
        n_chk++;
        if (rx_last[16] !== 1'b1 || in_ready !== 1'b1)
            $display("FAIL bp_end: last=%b rdy=%b want 1 1", rx_last[16], in_ready);
        else n_pass++;
    endtask

    task automatic test_invalid;
        string exp;
        int bad, errbad;
        exp = "11 ?? ?? 55 ?? 45";
        send(pack6(11, 60, 7, 55, 200, 45));
        recv(17, 1'b0);
        bad = 0; errbad = 0;
        for (int i = 0; i < 17; i++) begin
            if (rx_data[i] !== exp[i]) bad++;
            if (rx_err[i] !== (i >= 3)) errbad++;
        end
        n_chk++;
        if (rx_n != 17 || bad != 0) $display("FAIL inv_seq: got %0d chars with %0d wrong, want 17 with 0", rx_n, bad);
        else n_pass++;
        n_chk++;
        if (errbad != 0) $display("FAIL inv_err_timing: %0d chars with wrong err, want 0", errbad);
        else n_pass++;
        n_chk++;
        if (err !== 1'b1) $display("FAIL inv_err_sticky: err=%b in idle, want 1", err);
        else n_pass++;
        send(pack6(23, 15, 31, 31, 34, 52));
        n_chk++;
        if (err !== 1'b0) $display("FAIL inv_err_clear: err=%b after new accept, want 0", err);
        else n_pass++;
        recv(17, 1'b0);
    endtask

    task automatic test_back_to_back;
        string expa, expb;
        int bada, badb;
        expa = "23 15 31 31 34 52";
        expb = "44 12 33 21 53 14";
        in_text  = pack6(23, 15, 31, 31, 34, 52);
        in_valid = 1'b1;
        @(negedge clk);
        in_text = pack6(44, 12, 33, 21, 53, 14);
        recv(17, 1'b0);
        bada = 0;
        for (int i = 0; i < 17; i++) if (rx_data[i] !== expa[i]) bada++;
        n_chk++;
        if (bada != 0 || rx_rdy_bad != 0)
            $display("FAIL b2b_a: %0d wrong chars, in_ready high %0d times, want 0 0", bada, rx_rdy_bad);
        else n_pass++;
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL b2b_gap: rdy=%b vld=%b want 1 0", in_ready, out_valid);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        recv(17, 1'b0);
        badb = 0;
        for (int i = 0; i < 17; i++) if (rx_data[i] !== expb[i]) badb++;
        n_chk++;
        if (rx_n != 17 || badb != 0 || rx_cycles != 17)
            $display("FAIL b2b_b: %0d chars, %0d wrong, %0d cycles, want 17 0 17", rx_n, badb, rx_cycles);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        string exp;
        int bad;
        exp = "44 12 33 21 53 14";
        send(pack6(23, 15, 31, 31, 34, 52));
        recv(5, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00 || err !== 1'b0)
            $display("FAIL rst_mid: vld=%b rdy=%b data=%h err=%b want 0 1 00 0", out_valid, in_ready, out_data, err);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0) $display("FAIL rst_quiet: vld=%b after release, want 0", out_valid);
        else n_pass++;
        send(pack6(44, 12, 33, 21, 53, 14));
        recv(17, 1'b0);
        bad = 0;
        for (int i = 0; i < 17; i++) if (rx_data[i] !== exp[i]) bad++;
        n_chk++;
        if (rx_n != 17 || bad != 0 || rx_last[16] !== 1'b1)
            $display("FAIL rst_after: %0d chars, %0d wrong, last=%b want 17 0 1", rx_n, bad, rx_last[16]);
        else n_pass++;
    endtask

    task automatic test_len1;
        in_text1  = 8'd35;
        in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        n_chk++;
        if (out_valid1 !== 1'b1 || out_data1 !== 8'h33 || out_last1 !== 1'b0)
            $display("FAIL len1_tens: vld=%b data=%h last=%b want 1 33 0", out_valid1, out_data1, out_last1);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (out_valid1 !== 1'b1 || out_data1 !== 8'h35 || out_last1 !== 1'b1)
            $display("FAIL len1_units: vld=%b data=%h last=%b want 1 35 1", out_valid1, out_data1, out_last1);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1)
            $display("FAIL len1_end: vld=%b rdy=%b want 0 1", out_valid1, in_ready1);
        else n_pass++;
    endtask

    initial begin
        #12;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_basic;
        test_backpressure;
        test_invalid;
        test_back_to_back;
        test_reset_mid;
        test_len1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/polybius_digit_serializer.md
# polybius_digit_serializer

Downstream stage of the combinational Polybius `encryptor`. It captures one complete encrypted message of `MSG_LEN` code bytes, where each byte is row*10+column. It then streams the message out one ASCII character per cycle, as decimal digit pairs separated by a configurable character, under a valid/ready handshake. It decouples the parallel cipher datapath from serial consumers such as a UART TX or a log FIFO.

## Interface
- `MSG_LEN`, default 6: number of code bytes per message; must be ≥1.
- `SEP_CHAR`, default 8'h20 (space): separator emitted between code pairs.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  `in_text` holds a complete encrypted message.
- `in_ready`  out  1  block can accept a message; high only in IDLE.
- `in_text`  in  8*MSG_LEN  packed codes; byte i at [8i+7:8i]; byte 0 is emitted first.
- `out_valid`  out  1  `out_data` holds a valid character.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `out_data`  out  8  ASCII character.
- `out_last`  out  1  high with the final character of the message.
- `err`  out  1  sticky: at least one code in the current/last message was invalid.

## Operation
- States: IDLE, TENS, UNITS, SEP.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: register all of `in_text`, clear index to 0, clear `err`, go to TENS.
- TENS: present the tens character of byte[index]; advance to UNITS on the handshake.
- UNITS: present the units character of byte[index].
  - On the handshake with index==MSG_LEN-1: go to IDLE.
  - On the handshake otherwise: go to SEP.
- SEP: present `SEP_CHAR`; on the handshake, increment index and go to TENS.
- Code validity:
  - A code v is valid iff v≤99 and both v/10 and v%10 are in 1..5.
  - Valid code: tens char = 8'h30+v/10; units char = 8'h30+v%10.
  - Invalid code: both chars are 8'h3F ('?'), and `err` is set when its TENS character is presented.
- `err` stays high until the next message is accepted or until reset.
- Output sequence per message has 3*MSG_LEN-1 characters. For MSG_LEN=1 it has 2 characters and there is no SEP.
- `out_last`=1 only in UNITS with index==MSG_LEN-1.
- Index counter width is $clog2(MSG_LEN) bits, minimum 1. It never exceeds MSG_LEN-1.
- Upstream changes to `in_text` after capture have no effect on the message in flight.

## Timing
- Reset values, while `rst_n`=0: state IDLE, `in_ready`=1, `out_valid`=0, `out_last`=0, `out_data`=8'h00, `err`=0, index 0.
- Reset applied mid-message aborts it immediately: no further characters are emitted, and the captured message is discarded.
- Latency: message accepted at edge N; the first character is valid in the cycle following edge N.
- `out_valid`=1 in every state except IDLE.
- `in_ready` and `out_valid` are never both high.
- Handshake: a character transfers on a rising edge with `out_valid`&&`out_ready`=1.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
- `out_valid` never drops without a transfer.
- Throughput: one character per cycle with `out_ready` held high. A full message occupies 3*MSG_LEN-1 cycles.
- After the transfer of the last character, `in_ready`=1 in the next cycle. A new message can be accepted on that edge, giving one idle output cycle between messages.
- `in_valid` while not in IDLE is ignored. Upstream must hold `in_valid` and `in_text` until `in_ready`.
- All outputs are registered or decoded from state and registers only. There is no combinational path from `in_*` or `out_ready` to any output.

## Test plan
- Basic: MSG_LEN=6, load codes 23,15,31,31,34,52 with `out_ready`=1.
  - Expected output: "23 15 31 31 34 52", 17 characters on consecutive cycles.
  - `out_last` high only on the final '2'; `err`=0; `in_ready` returns high the cycle after.
- Backpressure: same message, with `out_ready` toggled pseudo-randomly.
  - Expected: identical character sequence.
  - `out_data` stable across every stall cycle; no duplicated or dropped characters.
- Invalid codes: load 11,60,7,55,200,45.
  - Expected output: "11 ?? ?? 55 ?? 45".
  - `err` rises when byte 1's TENS character is presented and stays high through the end of the message.
  - `err` clears when the next valid message is accepted.
- Back-to-back: hold `in_valid` high with message A, then change to message B after A is accepted.
  - Expected: B is not accepted until the cycle after A's `out_last` transfer.
  - B streams correctly; `in_text` changes during A do not corrupt A.
- Reset mid-operation: assert `rst_n`=0 asynchronously after the 5th character.
  - Expected: `out_valid`=0 and `in_ready`=1 immediately.
  - After release, a new message 44,12,33,21,53,14 streams as "44 12 33 21 53 14".
- MSG_LEN=1: load 35.
  - Expected: "3","5", with `out_last` on "5"; no separator emitted.
